// File: rtl/vdg_pkg.sv
// Shared constants and decode helpers for the VDG fetch sequencer.
// Cell geometry, mode-field positions and row-repeat decoding live here.
package vdg_pkg;
  localparam int CELL_W         = 8;
  localparam int CELL_BITS      = 3;
  localparam int BYTES_PER_LINE = 32;
  localparam int COL_W          = 5;
  localparam int FETCH_END      = CELL_W * BYTES_PER_LINE;
  localparam int ROW_W          = 4;
  localparam int MODE_GFX       = 3;
  localparam int MODE_DIV       = 0;

  localparam logic [CELL_BITS-1:0] PH_CPU  = 3'd4;
  localparam logic [CELL_BITS-1:0] PH_LOAD = 3'd7;
  localparam logic [CELL_BITS-1:0] PH_IDLE = 3'd0;

  typedef enum logic {SLOT_VIDEO = 1'b0, SLOT_CPU = 1'b1} slot_e;

  // Lines per character/graphics row for a given mode.
  function automatic logic [ROW_W-1:0] row_repeat(input logic [3:0] mode);
    logic [ROW_W-1:0] r;
    if (!mode[MODE_GFX]) begin
      r = 4'd12;
    end else begin
      case (mode[2:1])
        2'b10:   r = 4'd2;
        2'b11:   r = 4'd1;
        default: r = 4'd3;
      endcase
    end
    return r;
  endfunction
endpackage

// File: rtl/vdg_fetch_sequencer_if.sv
// Bus/shifter-side signal bundle of the VDG fetch sequencer.
// master = the sequencer, slave = the RAM/CPU/shifter environment.
interface vdg_fetch_sequencer_if;
  import vdg_pkg::*;

  logic [3:0]       mode;
  logic [15:0]      vid_base;
  logic             cpu_req;
  logic             cpu_grant;
  logic             mem_video;
  logic [15:0]      vid_addr;
  logic             load;
  logic             divider;
  logic [ROW_W-1:0] line_in_row;
  logic             blank_n;
  logic             hsync_n;
  logic             vsync_n;
  logic             fs_n;

  modport master (
    input  mode, vid_base, cpu_req,
    output cpu_grant, mem_video, vid_addr, load, divider, line_in_row,
           blank_n, hsync_n, vsync_n, fs_n
  );

  modport slave (
    output mode, vid_base, cpu_req,
    input  cpu_grant, mem_video, vid_addr, load, divider, line_in_row,
           blank_n, hsync_n, vsync_n, fs_n
  );
endinterface

// File: rtl/vdg_timing.sv
// Raster counters plus registered sync/blank generation for the VDG path.
// Pins are decoded from the next-count value so they line up with hcount.
module vdg_timing
  import vdg_pkg::*;
#(
  parameter int H_TOTAL     = 456,
  parameter int HSYNC_START = 320,
  parameter int HSYNC_LEN   = 32,
  parameter int V_TOTAL     = 262,
  parameter int V_ACTIVE    = 192,
  parameter int VSYNC_START = 224,
  parameter int H_W         = $clog2(H_TOTAL),
  parameter int V_W         = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           reset_n,
  output logic [H_W-1:0] hcount_nxt,
  output logic [V_W-1:0] vcount,
  output logic [V_W-1:0] vcount_nxt,
  output logic           line_end,
  output logic           frame_end,
  output logic           blank_n,
  output logic           hsync_n,
  output logic           vsync_n,
  output logic           fs_n
);
  logic [H_W-1:0] hcount_q, hcount_d;
  logic [V_W-1:0] vcount_q, vcount_d;
  logic           blank_n_q, blank_n_d;
  logic           hsync_n_q, hsync_n_d;
  logic           vsync_n_q, vsync_n_d;
  logic           fs_n_q, fs_n_d;
  logic           active_d;

  always_comb begin
    line_end  = (hcount_q == H_W'(H_TOTAL - 1));
    frame_end = line_end && (vcount_q == V_W'(V_TOTAL - 1));
    hcount_d  = line_end ? '0 : hcount_q + 1'b1;
    vcount_d  = vcount_q;
    if (frame_end)     vcount_d = '0;
    else if (line_end) vcount_d = vcount_q + 1'b1;

    active_d  = (vcount_d < V_W'(V_ACTIVE));
    // Pixels trail their fetch by one cell.
    blank_n_d = active_d && (hcount_d >= H_W'(CELL_W)) &&
                (hcount_d < H_W'(FETCH_END + CELL_W));
    hsync_n_d = !((hcount_d >= H_W'(HSYNC_START)) &&
                  (hcount_d < H_W'(HSYNC_START + HSYNC_LEN)));
    vsync_n_d = !((vcount_d >= V_W'(VSYNC_START)) &&
                  (vcount_d < V_W'(VSYNC_START + 3)));
    fs_n_d    = active_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q  <= '0;
      vcount_q  <= '0;
      blank_n_q <= 1'b0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      fs_n_q    <= 1'b1;
    end else begin
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      blank_n_q <= blank_n_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      fs_n_q    <= fs_n_d;
    end
  end

  assign hcount_nxt = hcount_d;
  assign vcount     = vcount_q;
  assign vcount_nxt = vcount_d;
  assign blank_n    = blank_n_q;
  assign hsync_n    = hsync_n_q;
  assign vsync_n    = vsync_n_q;
  assign fs_n       = fs_n_q;
endmodule

// File: rtl/vdg_fetch_sequencer.sv
// VDG fetch sequencer: video RAM fetch addressing, shifter load/divider,
// and video/CPU time-slicing of the shared memory bus.
module vdg_fetch_sequencer
  import vdg_pkg::*;
#(
  parameter int H_TOTAL     = 456,
  parameter int HSYNC_START = 320,
  parameter int HSYNC_LEN   = 32,
  parameter int V_TOTAL     = 262,
  parameter int V_ACTIVE    = 192,
  parameter int VSYNC_START = 224
) (
  input  logic                  clk,
  input  logic                  reset_n,
  vdg_fetch_sequencer_if.master bus
);
  localparam int H_W = $clog2(H_TOTAL);
  localparam int V_W = $clog2(V_TOTAL);

  logic [H_W-1:0]       hcount_nxt;
  logic [V_W-1:0]       vcount, vcount_nxt;
  logic                 line_end, frame_end;

  logic [3:0]           mode_q, mode_d;
  logic                 divider_q, divider_d;
  logic [15:0]          row_addr_q, row_addr_d;
  logic [ROW_W-1:0]     line_in_row_q, line_in_row_d;
  logic [15:0]          vid_addr_q, vid_addr_d;
  logic                 load_q, load_d;
  logic                 mem_video_q, mem_video_d;
  logic                 cpu_grant_q, cpu_grant_d;
  logic                 frame_pend_q, frame_pend_d;
  logic [ROW_W-1:0]     rpt;
  logic                 fetch_d;
  logic [CELL_BITS-1:0] phase_d;
  slot_e                slot_d;

  vdg_timing #(
    .H_TOTAL(H_TOTAL), .HSYNC_START(HSYNC_START), .HSYNC_LEN(HSYNC_LEN),
    .V_TOTAL(V_TOTAL), .V_ACTIVE(V_ACTIVE), .VSYNC_START(VSYNC_START),
    .H_W(H_W), .V_W(V_W)
  ) u_timing (
    .clk(clk), .reset_n(reset_n),
    .hcount_nxt(hcount_nxt), .vcount(vcount), .vcount_nxt(vcount_nxt),
    .line_end(line_end), .frame_end(frame_end),
    .blank_n(bus.blank_n), .hsync_n(bus.hsync_n),
    .vsync_n(bus.vsync_n), .fs_n(bus.fs_n)
  );

  always_comb begin
    mode_d        = mode_q;
    divider_d     = divider_q;
    row_addr_d    = row_addr_q;
    line_in_row_d = line_in_row_q;
    frame_pend_d  = 1'b0;
    rpt           = row_repeat(mode_q);

    if (line_end) begin
      mode_d    = bus.mode;
      divider_d = bus.mode[MODE_GFX] & bus.mode[MODE_DIV];
    end

    // Leaving reset is treated as a frame start so line 0 fetches from vid_base.
    if (frame_pend_q || frame_end) begin
      row_addr_d    = bus.vid_base;
      line_in_row_d = '0;
    end else if (line_end && (vcount < V_W'(V_ACTIVE))) begin
      // >= so a shrinking row repeat still closes the current row.
      if (line_in_row_q >= rpt - ROW_W'(1)) begin
        row_addr_d    = row_addr_q + 16'(BYTES_PER_LINE);
        line_in_row_d = '0;
      end else begin
        line_in_row_d = line_in_row_q + 1'b1;
      end
    end

    fetch_d     = (vcount_nxt < V_W'(V_ACTIVE)) && (hcount_nxt < H_W'(FETCH_END));
    phase_d     = hcount_nxt[CELL_BITS-1:0];
    slot_d      = slot_e'(phase_d[CELL_BITS-1]);
    mem_video_d = fetch_d && (slot_d == SLOT_VIDEO);
    load_d      = fetch_d && (phase_d == PH_LOAD);
    cpu_grant_d = bus.cpu_req &&
                  ((phase_d == PH_CPU) || (!fetch_d && (phase_d == PH_IDLE)));
    vid_addr_d  = fetch_d ? row_addr_d + 16'(hcount_nxt[CELL_BITS +: COL_W])
                          : vid_addr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q        <= '0;
      divider_q     <= 1'b0;
      row_addr_q    <= '0;
      line_in_row_q <= '0;
      vid_addr_q    <= '0;
      load_q        <= 1'b0;
      mem_video_q   <= 1'b0;
      cpu_grant_q   <= 1'b0;
      frame_pend_q  <= 1'b1;
    end else begin
      mode_q        <= mode_d;
      divider_q     <= divider_d;
      row_addr_q    <= row_addr_d;
      line_in_row_q <= line_in_row_d;
      vid_addr_q    <= vid_addr_d;
      load_q        <= load_d;
      mem_video_q   <= mem_video_d;
      cpu_grant_q   <= cpu_grant_d;
      frame_pend_q  <= frame_pend_d;
    end
  end

  assign bus.divider     = divider_q;
  assign bus.line_in_row = line_in_row_q;
  assign bus.vid_addr    = vid_addr_q;
  assign bus.load        = load_q;
  assign bus.mem_video   = mem_video_q;
  assign bus.cpu_grant   = cpu_grant_q;
endmodule
